// File: rtl/spm_dcache_responder.sv
// Scratchpad SRAM on the responder side of a D$ request port.
// Define SPM_OOR_CNT_EN to add the saturating out-of-range counter port.
package spm_dcache_pkg;
    localparam int XLEN               = 64;
    localparam int DCACHE_INDEX_WIDTH = 12;
    localparam int DCACHE_TAG_WIDTH   = 44;

    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] address_index;
        logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
        logic [XLEN-1:0]               data_wdata;
        logic                          data_req;
        logic                          data_we;
        logic [(XLEN/8)-1:0]           data_be;
        logic [1:0]                    data_size;
        logic                          kill_req;
        logic                          tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic            data_gnt;
        logic            data_rvalid;
        logic [XLEN-1:0] data_rdata;
    } dcache_req_o_t;
endpackage

module spm_dcache_responder
    import spm_dcache_pkg::*;
#(
    parameter int unsigned NumWords = 1024,
    parameter logic [63:0] BaseAddr = 64'h0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  dcache_req_i_t req_port_i,
    output dcache_req_o_t req_port_o
`ifdef SPM_OOR_CNT_EN
    ,
    output logic [15:0]   oor_cnt_o
`endif
);

    localparam int unsigned IdxW     = $clog2(NumWords);
    localparam int unsigned AddrLsb  = $clog2(XLEN / 8);
    localparam logic [63:0] WinBytes = 64'(NumWords) * 64'(XLEN / 8);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TAG,
        RESP
    } state_e;

    state_e                        state_q, state_d;
    logic [DCACHE_INDEX_WIDTH-1:0] index_q, index_d;
    logic [XLEN-1:0]               rdata_q, rdata_d;

    logic [XLEN-1:0] mem_q [NumWords];

    logic [63:0]     wr_addr;
    logic [63:0]     rd_addr;
    logic [IdxW-1:0] wr_idx;
    logic [IdxW-1:0] rd_idx;
    logic            wr_in;
    logic            rd_in;
    logic            gnt;
    logic            wr_gnt;
    logic            wr_en;
    logic            rd_tag;
    logic            unused_size;

    function automatic logic in_win(input logic [63:0] a);
        return (a >= BaseAddr) && ((a - BaseAddr) < WinBytes);
    endfunction

    assign unused_size = ^req_port_i.data_size;

    // Writes carry their tag in the grant cycle; reads combine the
    // latched index with the tag presented in the tag phase.
    assign wr_addr = 64'({req_port_i.address_tag, req_port_i.address_index});
    assign rd_addr = 64'({req_port_i.address_tag, index_q});
    assign wr_idx  = wr_addr[AddrLsb +: IdxW];
    assign rd_idx  = rd_addr[AddrLsb +: IdxW];
    assign wr_in   = in_win(wr_addr);
    assign rd_in   = in_win(rd_addr);

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        rdata_d = rdata_q;
        gnt     = 1'b0;
        wr_gnt  = 1'b0;
        rd_tag  = 1'b0;
        unique case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                gnt     = req_port_i.data_req && !rst_i;
                if (gnt) begin
                    if (req_port_i.data_we) begin
                        wr_gnt = 1'b1;
                    end else begin
                        index_d = req_port_i.address_index;
                        state_d = WAIT_TAG;
                    end
                end
            end
            WAIT_TAG: begin
                if (req_port_i.kill_req) begin
                    state_d = IDLE;
                end else if (req_port_i.tag_valid) begin
                    rd_tag  = 1'b1;
                    rdata_d = rd_in ? mem_q[rd_idx] : '0;
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_en = wr_gnt && wr_in;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            index_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int i = 0; i < XLEN / 8; i++) begin
                if (req_port_i.data_be[i]) begin
                    mem_q[wr_idx][i*8 +: 8] <= req_port_i.data_wdata[i*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        req_port_o             = '0;
        req_port_o.data_gnt    = gnt;
        req_port_o.data_rvalid = (state_q == RESP);
        req_port_o.data_rdata  = rdata_q;
    end

`ifdef SPM_OOR_CNT_EN
    logic [15:0] oor_q, oor_d;
    logic        oor_inc;

    // Killed reads never reach rd_tag, so they are not counted.
    assign oor_inc = (wr_gnt && !wr_in) || (rd_tag && !rd_in);

    always_comb begin
        oor_d = oor_q;
        if (oor_inc && (oor_q != 16'hFFFF)) begin
            oor_d = oor_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            oor_q <= '0;
        end else begin
            oor_q <= oor_d;
        end
    end

    assign oor_cnt_o = oor_q;
`endif

endmodule
